// File: rtl/axi_txn_limiter.sv
// axi_txn_limiter: caps outstanding AXI writes/reads between a slave and a master port
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   slv_req_i / slv_resp_o   upstream request in, response out
//   mst_req_o / mst_resp_i   downstream request out, response in
//   wr_cnt_o / rd_cnt_o      live outstanding write / read counts
//   wr_full_o / rd_full_o    count at its cap; AW / AR blocked while set
//   err_o                    sticky: B or last R accepted while its count was 0
package axi_txn_limiter_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_chan_t;
  typedef aw_chan_t ar_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;
endpackage

module axi_txn_limiter #(
  parameter type aw_chan_t = axi_txn_limiter_pkg::aw_chan_t,
  parameter type w_chan_t = axi_txn_limiter_pkg::w_chan_t,
  parameter type b_chan_t = axi_txn_limiter_pkg::b_chan_t,
  parameter type ar_chan_t = axi_txn_limiter_pkg::ar_chan_t,
  parameter type r_chan_t = axi_txn_limiter_pkg::r_chan_t,
  parameter type req_t = axi_txn_limiter_pkg::req_t,
  parameter type resp_t = axi_txn_limiter_pkg::resp_t,
  parameter int unsigned MaxWrTxns = 8,
  parameter int unsigned MaxRdTxns = 8,
  parameter int unsigned WrCntW = $clog2(MaxWrTxns + 1),
  parameter int unsigned RdCntW = $clog2(MaxRdTxns + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  req_t              slv_req_i,
  output resp_t             slv_resp_o,
  output req_t              mst_req_o,
  input  resp_t             mst_resp_i,
  output logic [WrCntW-1:0] wr_cnt_o,
  output logic [RdCntW-1:0] rd_cnt_o,
  output logic              wr_full_o,
  output logic              rd_full_o,
  output logic              err_o
);
  if (MaxWrTxns == 0 || MaxRdTxns == 0) begin : g_bad_cfg
    $fatal(1, "axi_txn_limiter: MaxWrTxns and MaxRdTxns must be >= 1");
  end
  logic [WrCntW-1:0] wr_cnt_d, wr_cnt_q;
  logic [RdCntW-1:0] rd_cnt_d, rd_cnt_q;
  logic err_d, err_q;
  logic wr_full, rd_full, wr_inc, wr_dec, rd_inc, rd_dec;
  always_comb begin
    wr_full = wr_cnt_q == WrCntW'(MaxWrTxns);
    rd_full = rd_cnt_q == RdCntW'(MaxRdTxns);
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = aw_chan_t'(slv_req_i.aw);
    mst_req_o.w        = w_chan_t'(slv_req_i.w);
    mst_req_o.ar       = ar_chan_t'(slv_req_i.ar);
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~wr_full;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~rd_full;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.b        = b_chan_t'(mst_resp_i.b);
    slv_resp_o.r        = r_chan_t'(mst_resp_i.r);
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~wr_full;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~rd_full;
    wr_inc = slv_req_i.aw_valid & mst_resp_i.aw_ready & ~wr_full;
    rd_inc = slv_req_i.ar_valid & mst_resp_i.ar_ready & ~rd_full;
    wr_dec = mst_resp_i.b_valid & slv_req_i.b_ready;
    rd_dec = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    // inc is impossible while full, so only the zero floor needs guarding
    wr_cnt_d = (wr_inc == wr_dec) ? wr_cnt_q :
               wr_inc ? wr_cnt_q + WrCntW'(1) :
               (wr_cnt_q == '0) ? wr_cnt_q : wr_cnt_q - WrCntW'(1);
    rd_cnt_d = (rd_inc == rd_dec) ? rd_cnt_q :
               rd_inc ? rd_cnt_q + RdCntW'(1) :
               (rd_cnt_q == '0) ? rd_cnt_q : rd_cnt_q - RdCntW'(1);
    err_d = err_q | (wr_dec & (wr_cnt_q == '0)) | (rd_dec & (rd_cnt_q == '0));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end
  assign wr_cnt_o  = wr_cnt_q;
  assign rd_cnt_o  = rd_cnt_q;
  assign wr_full_o = wr_full;
  assign rd_full_o = rd_full;
  assign err_o     = err_q;
endmodule

// File: tb/tb_axi_txn_limiter.sv
// tb_axi_txn_limiter: directed corner cases on a 2/1 limiter, randomized scoreboard traffic on a 4/4 limiter
module tb_axi_txn_limiter;
  import axi_txn_limiter_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  req_t d_slv_req, d_mst_req, r_slv_req, r_mst_req;
  resp_t d_slv_resp, d_mst_resp, r_slv_resp, r_mst_resp;
  logic [1:0] d_wr_cnt;
  logic d_rd_cnt;
  logic [2:0] r_wr_cnt, r_rd_cnt;
  logic d_wr_full, d_rd_full, d_err, r_wr_full, r_rd_full, r_err;
  int total = 0, bad = 0;
  bit rnd_on = 1'b0;
  int m_wr = 0, m_rd = 0;
  aw_chan_t aw_q[$];
  ar_chan_t ar_q[$];
  w_chan_t w_q[$];
  b_chan_t b_q[$];
  r_chan_t r_q[$];
  axi_txn_limiter #(.MaxWrTxns(2), .MaxRdTxns(1)) u_dir (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(d_slv_req), .slv_resp_o(d_slv_resp),
    .mst_req_o(d_mst_req), .mst_resp_i(d_mst_resp), .wr_cnt_o(d_wr_cnt), .rd_cnt_o(d_rd_cnt),
    .wr_full_o(d_wr_full), .rd_full_o(d_rd_full), .err_o(d_err)
  );
  axi_txn_limiter #(.MaxWrTxns(4), .MaxRdTxns(4)) u_rnd (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(r_slv_req), .slv_resp_o(r_slv_resp),
    .mst_req_o(r_mst_req), .mst_resp_i(r_mst_resp), .wr_cnt_o(r_wr_cnt), .rd_cnt_o(r_rd_cnt),
    .wr_full_o(r_wr_full), .rd_full_o(r_rd_full), .err_o(r_err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: handshake seen, want none (scoreboard empty)", name);
  endtask
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Scoreboard monitor: pops expected payloads at each output handshake, tracks spec counts
  always @(negedge clk) if (rnd_on) begin
    chk("wr_cnt", r_wr_cnt, m_wr);
    chk("rd_cnt", r_rd_cnt, m_rd);
    chk("wr_max", r_wr_cnt <= 4, 1);
    chk("rd_max", r_rd_cnt <= 4, 1);
    chk("wr_full", r_wr_full, m_wr == 4);
    chk("rd_full", r_rd_full, m_rd == 4);
    chk("aw_gate", {r_mst_req.aw_valid, r_slv_resp.aw_ready},
        {r_slv_req.aw_valid && m_wr < 4, r_mst_resp.aw_ready && m_wr < 4});
    chk("ar_gate", {r_mst_req.ar_valid, r_slv_resp.ar_ready},
        {r_slv_req.ar_valid && m_rd < 4, r_mst_resp.ar_ready && m_rd < 4});
    chk("thru", {r_mst_req.w_valid, r_slv_resp.w_ready, r_slv_resp.b_valid, r_mst_req.b_ready,
                 r_slv_resp.r_valid, r_mst_req.r_ready},
        {r_slv_req.w_valid, r_mst_resp.w_ready, r_mst_resp.b_valid, r_slv_req.b_ready,
         r_mst_resp.r_valid, r_slv_req.r_ready});
    chk("err", r_err, 0);
    if (r_mst_req.aw_valid && r_mst_resp.aw_ready) begin
      if (aw_q.size() == 0) miss("aw"); else chk("aw_data", r_mst_req.aw, aw_q.pop_front());
      m_wr++;
    end
    if (r_mst_req.ar_valid && r_mst_resp.ar_ready) begin
      if (ar_q.size() == 0) miss("ar"); else chk("ar_data", r_mst_req.ar, ar_q.pop_front());
      m_rd++;
    end
    if (r_mst_req.w_valid && r_mst_resp.w_ready) begin
      if (w_q.size() == 0) miss("w"); else chk("w_data", r_mst_req.w, w_q.pop_front());
    end
    if (r_slv_resp.b_valid && r_slv_req.b_ready) begin
      if (b_q.size() == 0) miss("b"); else chk("b_data", r_slv_resp.b, b_q.pop_front());
      if (m_wr > 0) m_wr--;
    end
    if (r_slv_resp.r_valid && r_slv_req.r_ready) begin
      if (r_q.size() == 0) miss("r"); else chk("r_data", r_slv_resp.r, r_q.pop_front());
      if (r_slv_resp.r.last && m_rd > 0) m_rd--;
    end
  end
  task automatic run_random;
    int wr_iss, rd_iss, wr_done, rd_done, sl_wr, sl_rd, cyc;
    logic aw_hs, ar_hs, w_hs, b_hs, r_hs, r_last;
    wr_iss = 0; rd_iss = 0; wr_done = 0; rd_done = 0; sl_wr = 0; sl_rd = 0; cyc = 0;
    rnd_on = 1'b1;
    while ((wr_done < 5000 || rd_done < 5000) && cyc < 80000) begin
      @(negedge clk);
      aw_hs  = r_slv_req.aw_valid & r_slv_resp.aw_ready;
      ar_hs  = r_slv_req.ar_valid & r_slv_resp.ar_ready;
      w_hs   = r_slv_req.w_valid & r_slv_resp.w_ready;
      b_hs   = r_slv_resp.b_valid & r_slv_req.b_ready;
      r_hs   = r_slv_resp.r_valid & r_slv_req.r_ready;
      r_last = r_slv_resp.r.last;
      step();
      cyc++;
      if (aw_hs) begin r_slv_req.aw_valid = 1'b0; sl_wr++; end
      if (ar_hs) begin r_slv_req.ar_valid = 1'b0; sl_rd++; end
      if (w_hs) r_slv_req.w_valid = 1'b0;
      if (b_hs) begin r_mst_resp.b_valid = 1'b0; sl_wr--; wr_done++; end
      if (r_hs) begin
        r_mst_resp.r_valid = 1'b0;
        if (r_last) begin sl_rd--; rd_done++; end
      end
      if (!r_slv_req.aw_valid && wr_iss < 5000 && $urandom_range(0, 3) != 0) begin
        r_slv_req.aw = aw_chan_t'(rnd64());
        r_slv_req.aw_valid = 1'b1;
        aw_q.push_back(r_slv_req.aw);
        wr_iss++;
      end
      if (!r_slv_req.ar_valid && rd_iss < 5000 && $urandom_range(0, 3) != 0) begin
        r_slv_req.ar = ar_chan_t'(rnd64());
        r_slv_req.ar_valid = 1'b1;
        ar_q.push_back(r_slv_req.ar);
        rd_iss++;
      end
      if (!r_slv_req.w_valid && $urandom_range(0, 1) != 0) begin
        r_slv_req.w = w_chan_t'(rnd64());
        r_slv_req.w_valid = 1'b1;
        w_q.push_back(r_slv_req.w);
      end
      if (!r_mst_resp.b_valid && sl_wr > 0 && $urandom_range(0, 1) != 0) begin
        r_mst_resp.b = b_chan_t'(rnd64());
        r_mst_resp.b_valid = 1'b1;
        b_q.push_back(r_mst_resp.b);
      end
      if (!r_mst_resp.r_valid && sl_rd > 0 && $urandom_range(0, 3) != 0) begin
        r_mst_resp.r = r_chan_t'(rnd64());
        r_mst_resp.r_valid = 1'b1;
        r_q.push_back(r_mst_resp.r);
      end
      r_mst_resp.aw_ready = $urandom_range(0, 3) != 0;
      r_mst_resp.ar_ready = $urandom_range(0, 3) != 0;
      r_mst_resp.w_ready  = $urandom_range(0, 1) != 0;
      r_slv_req.b_ready   = $urandom_range(0, 3) != 0;
      r_slv_req.r_ready   = $urandom_range(0, 3) != 0;
    end
    rnd_on = 1'b0;
    chk("rnd_budget", {wr_done >= 5000, rd_done >= 5000}, 2'b11);
  endtask
  initial begin
    d_slv_req = '0; d_mst_resp = '0; r_slv_req = '0; r_mst_resp = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d", {d_wr_cnt, d_rd_cnt, d_wr_full, d_rd_full, d_err}, 0);
    chk("rst_r", {r_wr_cnt, r_rd_cnt, r_wr_full, r_rd_full, r_err}, 0);
    rst_n = 1'b1;
    d_slv_req.aw_valid = 1'b1; d_slv_req.aw.addr = 32'h100; d_mst_resp.aw_ready = 1'b1;
    d_slv_req.b_ready = 1'b1;
    @(negedge clk);
    chk("aw1_pass", {d_mst_req.aw_valid, d_slv_resp.aw_ready}, 2'b11);
    chk("aw1_addr", d_mst_req.aw.addr, 32'h100);
    step(); d_slv_req.aw.addr = 32'h200;
    @(negedge clk);
    chk("aw2_pass", d_mst_req.aw_valid, 1);
    chk("aw2_cnt", d_wr_cnt, 1);
    step(); d_slv_req.aw.addr = 32'h300;
    @(negedge clk);
    chk("aw3_stall", {d_mst_req.aw_valid, d_slv_resp.aw_ready}, 2'b00);
    chk("aw3_full", {d_wr_cnt, d_wr_full}, {2'd2, 1'b1});
    chk("aw3_addr", d_mst_req.aw.addr, 32'h300);
    step();
    @(negedge clk);
    chk("aw3_hold", {d_wr_cnt, d_mst_req.aw_valid}, {2'd2, 1'b0});
    step(); d_mst_resp.b_valid = 1'b1; d_mst_resp.b.id = 4'h5;
    @(negedge clk);
    chk("b_pass", {d_slv_resp.b_valid, d_slv_resp.b.id}, {1'b1, 4'h5});
    chk("no_bypass", {d_wr_cnt, d_mst_req.aw_valid, d_slv_resp.aw_ready}, {2'd2, 2'b00});
    step(); d_mst_resp.b_valid = 1'b0;
    @(negedge clk);
    chk("unblock", {d_wr_cnt, d_wr_full, d_mst_req.aw_valid, d_slv_resp.aw_ready}, {2'd1, 3'b011});
    step(); d_slv_req.aw_valid = 1'b0;
    @(negedge clk);
    chk("refull", d_wr_cnt, 2);
    step(); d_mst_resp.b_valid = 1'b1;
    step(); d_mst_resp.b_valid = 1'b0;
    @(negedge clk);
    chk("cnt_one", d_wr_cnt, 1);
    step(); d_slv_req.aw_valid = 1'b1; d_mst_resp.b_valid = 1'b1;
    step(); d_slv_req.aw_valid = 1'b0; d_mst_resp.b_valid = 1'b0;
    @(negedge clk);
    chk("inc_dec", {d_wr_cnt, d_err}, {2'd1, 1'b0});
    step(); d_mst_resp.b_valid = 1'b1;
    step(); d_mst_resp.b_valid = 1'b0;
    @(negedge clk);
    chk("wr_drain", {d_wr_cnt, d_err}, 0);
    step(); d_slv_req.ar_valid = 1'b1; d_mst_resp.ar_ready = 1'b1; d_slv_req.r_ready = 1'b1;
    @(negedge clk);
    chk("ar1_pass", {d_mst_req.ar_valid, d_slv_resp.ar_ready}, 2'b11);
    step();
    for (int i = 0; i < 4; i++) begin
      d_mst_resp.r_valid = 1'b1; d_mst_resp.r.last = (i == 3); d_mst_resp.r.data = 32'hA0 + i;
      @(negedge clk);
      chk("burst_cnt", {d_rd_cnt, d_rd_full}, 2'b11);
      chk("ar2_block", {d_mst_req.ar_valid, d_slv_resp.ar_ready}, 2'b00);
      chk("r_data", d_slv_resp.r.data, 32'hA0 + i);
      step();
    end
    d_mst_resp.r_valid = 1'b0;
    @(negedge clk);
    chk("ar2_pass", {d_rd_cnt, d_rd_full, d_mst_req.ar_valid}, 3'b001);
    step(); d_slv_req.ar_valid = 1'b0;
    @(negedge clk);
    chk("ar2_cnt", {d_rd_cnt, d_rd_full}, 2'b11);
    step(); d_mst_resp.r_valid = 1'b1; d_mst_resp.r.last = 1'b1;
    step(); d_mst_resp.r_valid = 1'b0;
    @(negedge clk);
    chk("rd_drain", {d_rd_cnt, d_err}, 0);
    step(); d_mst_resp.b_valid = 1'b1;
    step(); d_mst_resp.b_valid = 1'b0;
    @(negedge clk);
    chk("underflow", {d_wr_cnt, d_err}, {2'd0, 1'b1});
    repeat (3) step();
    @(negedge clk);
    chk("err_sticky", d_err, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {d_err, d_wr_cnt, d_rd_cnt}, 0);
    step(); rst_n = 1'b1;
    step();
    run_random();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
